alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter N, default 32: operand/result width.
REQ-002 Parameter FLAGS_COUNT, default 5: ALU flag width.
REQ-003 Parameter TIMEOUT_CYCLES, default 64: DIV wait limit (timeout build only).
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  request present; req_ready  out  1  request accepted when both high.
REQ-007 req_op  in  4  ALU opcode (1=ADD … 11=NEG, 4=DIV, 3=MUL); req_a, req_b  in  N  operands; req_uns  in  1  unsigned flag.
REQ-008 alu_a, alu_b  out  N; alu_opcode  out  4; alu_uns  out  1  held ALU operand/control drive.
REQ-009 alu_start  out  1  divider start pulse.
REQ-010 alu_result, alu_high  in  N; alu_flags  in  FLAGS_COUNT; alu_finished  in  1  ALU outputs.
REQ-011 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-012 rsp_result, rsp_high  out  N; rsp_flags  out  FLAGS_COUNT; rsp_err  out  1  response payload.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 FSM states: IDLE, EXEC, CAPT, ARM, WAIT, DONE.
REQ-015 IDLE: req_ready=1, alu_opcode=0, alu_start=0; on req_valid latch req_op/a/b/uns into drive registers and go to EXEC.
REQ-016 Illegal opcode (0 or 12–15) in IDLE: go directly to DONE with rsp_err=1, rsp_result=0, rsp_high=0, rsp_flags=0; alu_opcode stays 0.
REQ-017 alu_a/alu_b/alu_opcode/alu_uns are held constant from EXEC through the capture cycle.
REQ-018 EXEC (1 cycle): non-DIV ops -> CAPT; DIV -> ARM, with alu_start=1 for exactly this cycle.
REQ-019 CAPT (1 cycle): sample alu_result, alu_high, alu_flags into rsp_*; rsp_err=0; -> DONE.
REQ-020 ARM (1 cycle): alu_start=0, alu_finished ignored; -> WAIT.
REQ-021 WAIT: when alu_finished=1, sample as in CAPT and go to DONE; otherwise remain.
REQ-022 Non-DIV latency: accept edge T, rsp_valid high from cycle T+3.
REQ-023 DONE: rsp_valid=1, payload stable while rsp_ready=0; on rsp_ready go to IDLE, alu_opcode returns to 0.
REQ-024 req_ready is 0 in every state except IDLE; there is no request accept in the DONE exit cycle.
REQ-025 rsp_high is meaningful only for MUL/DIV and carries the captured alu_high unchanged for all ops.

Reset
REQ-026 rst asserted at any time (including mid-WAIT): state=IDLE immediately.
REQ-027 Reset also clears all drive/response registers to 0, rsp_valid=0, alu_start=0, and the timeout counter.
REQ-028 First request accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro ALU_SEQ_TIMEOUT_EN defined: counter runs in WAIT; after TIMEOUT_CYCLES cycles without alu_finished -> DONE with rsp_err=1, rsp_result and rsp_high all ones, rsp_flags=0.
REQ-030 ALU_SEQ_TIMEOUT_EN undefined: no counter, WAIT is unbounded, and rsp_err is set only by REQ-016.

Verification
REQ-031 ADD a=5, b=7, rsp_ready=1 -> rsp_valid at T+3, rsp_result=12, ZERO flag=0, rsp_err=0.
REQ-032 DIV a=100, b=7 -> alu_start high exactly one cycle; response after alu_finished with rsp_result=14, rsp_high=2.
REQ-033 MUL a=0x00010000, b=0x00010000 -> rsp_result=0, rsp_high=1, rsp_err=0.
REQ-034 req_op=12 -> rsp_valid at T+1, rsp_err=1, result=0, alu_start never high, alu_opcode stays 0.
REQ-035 rsp_ready low for 5 cycles in DONE -> payload stable, req_ready=0; next request accepted after the handshake cycle.
REQ-036 Macro defined, alu_finished forced low -> rsp_err=1 and rsp_result=0xFFFFFFFF after TIMEOUT_CYCLES. Separately, rst pulsed mid-WAIT -> IDLE and all outputs 0.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle for alu_seq.
// slave = sequencer side, master = requester side.
interface alu_seq_if #(
  parameter int N = 32,
  parameter int FLAGS_COUNT = 5
);
  logic                   req_valid;
  logic                   req_ready;
  logic [3:0]             req_op;
  logic [N-1:0]           req_a;
  logic [N-1:0]           req_b;
  logic                   req_uns;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [N-1:0]           rsp_result;
  logic [N-1:0]           rsp_high;
  logic [FLAGS_COUNT-1:0] rsp_flags;
  logic                   rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_uns, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_high, rsp_flags, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_uns, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_high, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: runs one request at a time through an external ALU/divider.
// Optional macro ALU_SEQ_TIMEOUT_EN bounds the divider wait.
module alu_seq #(
  parameter int N = 32,
  parameter int FLAGS_COUNT = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   CLK,
  input  logic                   rst,
  alu_seq_if.slave               bus,
  output logic [N-1:0]           alu_a,
  output logic [N-1:0]           alu_b,
  output logic [3:0]             alu_opcode,
  output logic                   alu_uns,
  output logic                   alu_start,
  input  logic [N-1:0]           alu_result,
  input  logic [N-1:0]           alu_high,
  input  logic [FLAGS_COUNT-1:0] alu_flags,
  input  logic                   alu_finished,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE, EXEC, CAPT, ARM, WAIT, DONE
  } state_t;

  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_MAX = 4'd11;

  state_t state;
  state_t state_nx;
  logic   legal;
  logic   accept;
  logic   cap;
  logic   tmo;

  assign legal  = (bus.req_op != 4'd0) && (bus.req_op <= OP_MAX);
  assign accept = (state == IDLE) && bus.req_valid;
  assign cap    = (state == CAPT) || ((state == WAIT) && alu_finished);

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // fires on the last allowed WAIT cycle without a finish
  assign tmo = (state == WAIT) && !alu_finished
            && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // count consecutive WAIT cycles that saw no finish
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == WAIT) && !alu_finished) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo = 1'b0;
`endif

  // state register
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.req_valid) state_nx = legal ? EXEC : DONE;
      EXEC: state_nx = (alu_opcode == OP_DIV) ? ARM : CAPT;
      CAPT: state_nx = DONE;
      ARM:  state_nx = WAIT;
      WAIT: if (alu_finished || tmo) state_nx = DONE;
      DONE: if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state-decoded handshake and control outputs
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == DONE);
    busy          = (state != IDLE);
    alu_start     = (state == EXEC) && (alu_opcode == OP_DIV);
  end

  // operand/control drive held from accept through capture
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_uns    <= 1'b0;
      alu_opcode <= 4'd0;
    end else if (accept) begin
      alu_a      <= bus.req_a;
      alu_b      <= bus.req_b;
      alu_uns    <= bus.req_uns;
      alu_opcode <= legal ? bus.req_op : 4'd0;
    end else if ((state == DONE) && bus.rsp_ready) begin
      alu_opcode <= 4'd0;
    end
  end

  // response payload: error, capture or timeout
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      bus.rsp_result <= '0;
      bus.rsp_high   <= '0;
      bus.rsp_flags  <= '0;
      bus.rsp_err    <= 1'b0;
    end else if (accept && !legal) begin
      bus.rsp_result <= '0;
      bus.rsp_high   <= '0;
      bus.rsp_flags  <= '0;
      bus.rsp_err    <= 1'b1;
    end else if (cap) begin
      bus.rsp_result <= alu_result;
      bus.rsp_high   <= alu_high;
      bus.rsp_flags  <= alu_flags;
      bus.rsp_err    <= 1'b0;
    end else if (tmo) begin
      bus.rsp_result <= '1;
      bus.rsp_high   <= '1;
      bus.rsp_flags  <= '0;
      bus.rsp_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random + directed requests against a behavioural
// ALU/response model, with a per-cycle response compare process.
module tb_alu_seq;
  localparam int N   = 32;
  localparam int FC  = 5;
  localparam int TMO = 16;

  typedef struct packed {
    logic [N-1:0]  res;
    logic [N-1:0]  hi;
    logic [FC-1:0] fl;
    logic          err;
  } rsp_t;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  alu_a, alu_b, alu_result, alu_high;
  logic [3:0]    alu_opcode;
  logic          alu_uns, alu_start, alu_finished, busy;
  logic [FC-1:0] alu_flags;
  rsp_t          alu_m;
  rsp_t          last;
  rsp_t          pin;
  rsp_t          exp_q[$];
  int            checks = 0;
  int            failures = 0;

  alu_seq_if #(.N(N), .FLAGS_COUNT(FC)) bus();

  alu_seq #(
    .N(N), .FLAGS_COUNT(FC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_uns(alu_uns),
    .alu_start(alu_start),
    .alu_result(alu_result), .alu_high(alu_high),
    .alu_flags(alu_flags), .alu_finished(alu_finished),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Reference ALU: 1 ADD 2 SUB 3 MUL 4 DIV 5 AND 6 OR 7 XOR
  // 8 SLL 9 SRL 10 SRA 11 NEG; flags {uns,op[0],hi!=0,sign,zero}
  function automatic rsp_t alu_fn(input logic [3:0] op,
                                  input logic [N-1:0] a,
                                  input logic [N-1:0] b,
                                  input logic uns);
    rsp_t r;
    logic [2*N-1:0] ax, bx, p;
    int sh;
    r = '0;
    sh = int'(b[4:0]);
    case (op)
      4'd1: r.res = a + b;
      4'd2: r.res = a - b;
      4'd3: begin
        ax = uns ? {{N{1'b0}}, a} : {{N{a[N-1]}}, a};
        bx = uns ? {{N{1'b0}}, b} : {{N{b[N-1]}}, b};
        p = ax * bx;
        r.res = p[N-1:0];
        r.hi  = p[2*N-1:N];
      end
      4'd4: begin
        if (b == '0) begin
          r.res = '1;
          r.hi  = a;
        end else if (uns) begin
          r.res = a / b;
          r.hi  = a % b;
        end else if (a == {1'b1, {(N-1){1'b0}}} && b == '1) begin
          r.res = a;
          r.hi  = '0;
        end else begin
          r.res = $signed(a) / $signed(b);
          r.hi  = $signed(a) % $signed(b);
        end
      end
      4'd5:  r.res = a & b;
      4'd6:  r.res = a | b;
      4'd7:  r.res = a ^ b;
      4'd8:  r.res = a << sh;
      4'd9:  r.res = a >> sh;
      4'd10: r.res = $signed(a) >>> sh;
      4'd11: r.res = -a;
      default: r.res = '0;
    endcase
    r.fl = {uns, op[0], |r.hi, r.res[N-1], (r.res == '0)};
    return r;
  endfunction

  // expected response for one request
  function automatic rsp_t model(input logic [3:0] op,
                                 input logic [N-1:0] a,
                                 input logic [N-1:0] b,
                                 input logic uns,
                                 input int fin_dly);
    rsp_t r;
    r = '0;
    if (op == 4'd0 || op > 4'd11) begin
      r.err = 1'b1;
      return r;
    end
`ifdef ALU_SEQ_TIMEOUT_EN
    if (op == 4'd4 && fin_dly < 0) begin
      r.res = '1;
      r.hi  = '1;
      r.err = 1'b1;
      return r;
    end
`else
    if (fin_dly < -1) r.err = 1'b0;
`endif
    r = alu_fn(op, a, b, uns);
    r.err = 1'b0;
    return r;
  endfunction

  // external ALU; divider outputs are junk until finished
  assign alu_m = alu_fn(alu_opcode, alu_a, alu_b, alu_uns);
  assign alu_result = (alu_opcode == 4'd4 && !alu_finished)
                    ? 32'hDEADBEEF : alu_m.res;
  assign alu_high   = (alu_opcode == 4'd4 && !alu_finished)
                    ? 32'h0BADF00D : alu_m.hi;
  assign alu_flags  = (alu_opcode == 4'd4 && !alu_finished)
                    ? 5'h15 : alu_m.fl;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // response compare: every valid cycle against the queue head
  always @(negedge CLK) begin
    if (!rst && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_spurious: got valid expected none");
      end else begin
        chk("rsp_result", bus.rsp_result, exp_q[0].res);
        chk("rsp_high", bus.rsp_high, exp_q[0].hi);
        chk("rsp_flags", bus.rsp_flags, exp_q[0].fl);
        chk("rsp_err", bus.rsp_err, exp_q[0].err);
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  // one request; called at posedge+1 with the DUT idle
  task automatic do_txn(input logic [3:0] op,
                        input logic [N-1:0] a,
                        input logic [N-1:0] b,
                        input logic uns,
                        input int fin_dly,
                        input int hold);
    int  e, exp_e, starts, raise_at;
    bit  legal, seen;
    legal = (op != 4'd0) && (op <= 4'd11);
    raise_at = 1 + fin_dly;
    if (!legal) exp_e = 1;
    else if (op != 4'd4) exp_e = 3;
    else if (fin_dly < 0) exp_e = 3 + TMO;
    else exp_e = ((raise_at > 3) ? raise_at : 3) + 1;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_uns = uns;
    bus.rsp_ready = 1'b0;
    @(negedge CLK);
    chk("req_ready_idle", bus.req_ready, 1);
    exp_q.push_back(model(op, a, b, uns, fin_dly));
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    e = 1;
    starts = 0;
    seen = 0;
    while (!seen && e < 200) begin
      if (op == 4'd4 && fin_dly >= 0 && e >= raise_at)
        alu_finished = 1'b1;
      @(negedge CLK);
      starts += int'(alu_start);
      chk("req_ready_busy", bus.req_ready, 0);
      chk("busy", busy, 1);
      if (!legal) begin
        chk("opcode_illegal", alu_opcode, 0);
      end else if (!bus.rsp_valid) begin
        chk("drv_op", alu_opcode, op);
        chk("drv_a", alu_a, a);
        chk("drv_b", alu_b, b);
        chk("drv_uns", alu_uns, uns);
      end
      if (bus.rsp_valid) begin
        seen = 1;
      end else begin
        @(posedge CLK);
        #1;
        e++;
      end
    end
    alu_finished = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL rsp_wait: got no valid expected edge %0d", exp_e);
      return;
    end
    chk("latency", e, exp_e);
    chk("start_pulses", starts, (op == 4'd4) ? 1 : 0);
    last = '{bus.rsp_result, bus.rsp_high, bus.rsp_flags, bus.rsp_err};
    bus.req_valid = 1'b1;
    bus.req_op = 4'($urandom_range(1, 11));
    for (int k = 0; k < hold; k++) begin
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    @(posedge CLK);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge CLK);
    chk("hs_valid", bus.rsp_valid, 1);
    @(posedge CLK);
    #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge CLK);
    chk("idle_busy", busy, 0);
    chk("idle_valid", bus.rsp_valid, 0);
    chk("idle_opcode", alu_opcode, 0);
    chk("idle_req_ready", bus.req_ready, 1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = 4'd0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_uns = 1'b0;
    bus.rsp_ready = 1'b0;
    alu_finished = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_err", bus.rsp_err, 0);
    rst = 1'b0;

    pin = alu_fn(4'd1, 32'd5, 32'd7, 1'b0);
    chk("pin_add", pin.res, 12);
    pin = alu_fn(4'd4, 32'd100, 32'd7, 1'b0);
    chk("pin_div", {pin.hi, pin.res}, {32'd2, 32'd14});

    do_txn(4'd1, 32'd5, 32'd7, 1'b0, 0, 0);
    chk("add_res", last.res, 12);
    chk("add_zero", last.fl[0], 0);
    chk("add_err", last.err, 0);

    do_txn(4'd4, 32'd100, 32'd7, 1'b0, 3, 0);
    chk("div_res", last.res, 14);
    chk("div_high", last.hi, 2);

    do_txn(4'd3, 32'h0001_0000, 32'h0001_0000, 1'b0, 0, 1);
    chk("mul_res", last.res, 0);
    chk("mul_high", last.hi, 1);
    chk("mul_err", last.err, 0);

    do_txn(4'd12, 32'd9, 32'd3, 1'b0, 0, 0);
    chk("ill_err", last.err, 1);
    chk("ill_res", last.res, 0);

    do_txn(4'd2, 32'd3, 32'd5, 1'b1, 0, 5);
    chk("sub_res", last.res, 32'hFFFF_FFFE);

    do_txn(4'd4, 32'd50, 32'd5, 1'b1, 1, 0);
    chk("div_arm_res", last.res, 10);

`ifdef ALU_SEQ_TIMEOUT_EN
    do_txn(4'd4, 32'd100, 32'd7, 1'b0, -1, 1);
    chk("tmo_err", last.err, 1);
    chk("tmo_res", last.res, 32'hFFFF_FFFF);
    chk("tmo_high", last.hi, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [N-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 9))
                                      : N'($urandom);
      do_txn(op, a, b, 1'($urandom_range(0, 1)),
             $urandom_range(0, 6), $urandom_range(0, 4));
    end

    bus.req_valid = 1'b1;
    bus.req_op = 4'd4;
    bus.req_a = 32'd77;
    bus.req_b = 32'd3;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("midwait_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_valid", bus.rsp_valid, 0);
    chk("mr_req_ready", bus.req_ready, 1);
    chk("mr_start", alu_start, 0);
    chk("mr_opcode", alu_opcode, 0);
    chk("mr_a", alu_a, 0);
    chk("mr_b", alu_b, 0);
    chk("mr_uns", alu_uns, 0);
    chk("mr_result", bus.rsp_result, 0);
    chk("mr_high", bus.rsp_high, 0);
    chk("mr_err", bus.rsp_err, 0);
    @(posedge CLK);
    #1;
    rst = 1'b0;
    do_txn(4'd7, 32'hF0F0_1234, 32'h0FF0_4321, 1'b0, 0, 0);
    chk("post_rst_xor", last.res, 32'hFF00_5115);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
